// File: rtl/case_6_sdiv_12s_7s_12_seq.sv
// Multi-cycle signed restoring divider (truncating quotient/remainder) under an ap_start/ap_done handshake.
// Optional macro CASE_6_SDIV_ZERO_BYPASS_EN: a zero divisor skips the iteration phase.
module case_6_sdiv_12s_7s_12_seq #(
    parameter int din0_WIDTH = 12,
    parameter int din1_WIDTH = 7,
    parameter int dout_WIDTH = 12
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         ap_start,
    output logic                         ap_idle,
    output logic                         ap_ready,
    output logic                         ap_done,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic signed [din1_WIDTH-1:0] rem,
    output logic                         div_by_zero
);

    localparam int CW = (din0_WIDTH > 1) ? $clog2(din0_WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                  state_q;
    logic                    sgn_a_q;
    logic                    sgn_b_q;
    logic                    zero_q;
    logic [din0_WIDTH-1:0]   dvd_q;
    logic [din1_WIDTH-1:0]   dsr_q;
    logic [din1_WIDTH-1:0]   pr_q;
    logic [din1_WIDTH-1:0]   raw_lo_q;
    logic [CW-1:0]           cnt_q;
    logic                    done_q;

    logic [din1_WIDTH:0]     shf_d;
    logic                    qbit_d;
    logic [din1_WIDTH-1:0]   pr_d;

    // Quotient magnitude widened by one bit before negation, then truncated to the output width.
    function automatic logic [dout_WIDTH-1:0] fix_quo(input logic [din0_WIDTH-1:0] mag,
                                                      input logic neg);
        return neg ? dout_WIDTH'(-{1'b0, mag}) : dout_WIDTH'({1'b0, mag});
    endfunction

    function automatic logic [din1_WIDTH-1:0] fix_rem(input logic [din1_WIDTH-1:0] mag,
                                                      input logic neg);
        return neg ? -mag : mag;
    endfunction

    // Partial remainder stays below the divisor, so only the shifted value needs the extra bit.
    always_comb begin
        shf_d  = {pr_q, dvd_q[din0_WIDTH-1]};
        qbit_d = (shf_d >= {1'b0, dsr_q});
        pr_d   = qbit_d ? din1_WIDTH'(shf_d - {1'b0, dsr_q}) : shf_d[din1_WIDTH-1:0];
    end

    assign ap_idle  = (state_q == S_IDLE);
    assign ap_done  = done_q;
    assign ap_ready = done_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            dout        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        sgn_a_q     <= din0[din0_WIDTH-1];
                        sgn_b_q     <= din1[din1_WIDTH-1];
                        dvd_q       <= din0[din0_WIDTH-1] ? -din0 : din0;
                        dsr_q       <= din1[din1_WIDTH-1] ? -din1 : din1;
                        zero_q      <= (din1 == '0);
                        raw_lo_q    <= din0[din1_WIDTH-1:0];
                        pr_q        <= '0;
                        cnt_q       <= '0;
                        div_by_zero <= 1'b0;
`ifdef CASE_6_SDIV_ZERO_BYPASS_EN
                        state_q     <= (din1 == '0) ? S_DONE : S_CALC;
`else
                        state_q     <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    // Dividend bits shift out the top while quotient bits fill in from the bottom.
                    pr_q  <= pr_d;
                    dvd_q <= {dvd_q[din0_WIDTH-2:0], qbit_d};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(din0_WIDTH - 1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                    if (zero_q) begin
                        dout        <= '1;
                        rem         <= raw_lo_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        dout        <= fix_quo(dvd_q, sgn_a_q ^ sgn_b_q);
                        rem         <= fix_rem(pr_q, sgn_a_q);
                        div_by_zero <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
